// File: rtl/test_decade_counter.sv
// -----------------------------------------------------------------------------
// test_decade_counter
//
// 12-digit decimal up-counter (ones through hundred-billions), one 5-bit field
// per digit. While reset is low every digit is loaded from its slice of `init`.
// A slice above 9 loads as 0. After reset is released the counter advances by
// one on every rising clock edge and wraps from all-nines to all-zeros.
//
// Ports:
//   io_in[0]       clock, rising edge
//   io_in[1]       reset, asynchronous, active-low
//   io_in[2]       hold, active-high (only when COUNT_HOLD_EN is defined)
//   io_in[7:3]     reserved, ignored
//   init[59:0]     preload, 12 x 5 bits, init[4:0] = ones ... init[59:55] = hunB
//   ones .. hunB   digit outputs, 5 bits each, bit 4 always 0 in normal use
//
// Optional feature, selected at build time:
//   COUNT_HOLD_EN  when defined, io_in[2] = 1 on a rising edge freezes all
//                  digits. When undefined, io_in[2] is ignored.
// -----------------------------------------------------------------------------
module test_decade_counter (
  input  logic [7:0]  io_in,
  input  logic [59:0] init,
  output logic [4:0]  ones,
  output logic [4:0]  tens,
  output logic [4:0]  hund,
  output logic [4:0]  thou,
  output logic [4:0]  tenT,
  output logic [4:0]  hunT,
  output logic [4:0]  mil,
  output logic [4:0]  tenM,
  output logic [4:0]  hunM,
  output logic [4:0]  bil,
  output logic [4:0]  tenB,
  output logic [4:0]  hunB
);

  localparam int NUM_DIGITS = 12;

  logic clk;
  logic rst_n;
  logic hold;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];

`ifdef COUNT_HOLD_EN
  assign hold = io_in[2];
  logic unused_io;
  assign unused_io = &{1'b0, io_in[7:3]};
`else
  assign hold = 1'b0;
  logic unused_io;
  assign unused_io = &{1'b0, io_in[7:2]};
`endif

  logic [4:0]  digit_q    [NUM_DIGITS];
  logic [4:0]  init_digit [NUM_DIGITS];
  logic [4:0]  next_digit [NUM_DIGITS];
  logic [4:0]  view       [NUM_DIGITS];
  logic [NUM_DIGITS:0] carry;

  // Preload slices, with anything outside 0..9 forced to 0.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      init_digit[k] = (init[k*5 +: 5] > 5'd9) ? 5'd0 : init[k*5 +: 5];
    end
  end

  // Ripple carry: digit k steps when every lower digit is at (or above) 9.
  // A register above 9 is treated as 9 for carry and wraps to 0 on increment.
  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry[k]) begin
        next_digit[k] = (digit_q[k] >= 5'd9) ? 5'd0 : digit_q[k] + 5'd1;
      end else begin
        next_digit[k] = digit_q[k];
      end
      carry[k+1] = carry[k] & (digit_q[k] >= 5'd9);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digit_q[k] <= init_digit[k];
      end
    end else if (!hold) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        digit_q[k] <= next_digit[k];
      end
    end
  end

  // While reset is held the outputs follow `init` directly, so preload changes
  // made during reset show up without waiting for another reset edge.
  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      view[k] = rst_n ? digit_q[k] : init_digit[k];
    end
  end

  assign ones = view[0];
  assign tens = view[1];
  assign hund = view[2];
  assign thou = view[3];
  assign tenT = view[4];
  assign hunT = view[5];
  assign mil  = view[6];
  assign tenM = view[7];
  assign hunM = view[8];
  assign bil  = view[9];
  assign tenB = view[10];
  assign hunB = view[11];

endmodule

// File: tb/tb_test_decade_counter.sv
// -----------------------------------------------------------------------------
// tb_test_decade_counter
//
// Directed and randomized checks of test_decade_counter. The reference model
// holds the counter as a single integer in 0 .. 10^12-1 and derives each digit
// with division and modulo.
// -----------------------------------------------------------------------------
module tb_test_decade_counter;

  localparam longint MOD = 64'd1000000000000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic [4:0]  rsv = 5'd0;
  logic [7:0]  io_in;
  logic [59:0] init = '0;

  logic [4:0] ones, tens, hund, thou, tenT, hunT;
  logic [4:0] mil, tenM, hunM, bil, tenB, hunB;
  logic [4:0] dig [12];

  assign io_in = {rsv, hold, rst_n, clk};

  always #5 clk = ~clk;

  test_decade_counter dut (
    .io_in (io_in),
    .init  (init),
    .ones  (ones),
    .tens  (tens),
    .hund  (hund),
    .thou  (thou),
    .tenT  (tenT),
    .hunT  (hunT),
    .mil   (mil),
    .tenM  (tenM),
    .hunM  (hunM),
    .bil   (bil),
    .tenB  (tenB),
    .hunB  (hunB)
  );

  assign dig[0]  = ones;
  assign dig[1]  = tens;
  assign dig[2]  = hund;
  assign dig[3]  = thou;
  assign dig[4]  = tenT;
  assign dig[5]  = hunT;
  assign dig[6]  = mil;
  assign dig[7]  = tenM;
  assign dig[8]  = hunM;
  assign dig[9]  = bil;
  assign dig[10] = tenB;
  assign dig[11] = hunB;

  // ---------------- reference model ----------------
  longint model;
  longint pow10 [13];
  int     checks = 0;
  int     errors = 0;

  function automatic longint value_of_init(input logic [59:0] v);
    longint acc = 0;
    for (int k = 11; k >= 0; k--) begin
      int d = int'(v[k*5 +: 5]);
      if (d > 9) d = 0;
      acc = acc * 10 + longint'(d);
    end
    return acc;
  endfunction

  function automatic logic [59:0] pack_digits(input int d [12]);
    logic [59:0] v = '0;
    for (int k = 0; k < 12; k++) v[k*5 +: 5] = 5'(d[k]);
    return v;
  endfunction

  function automatic logic [59:0] pack_value(input longint n);
    logic [59:0] v = '0;
    longint r = n;
    for (int k = 0; k < 12; k++) begin
      v[k*5 +: 5] = 5'(r % 10);
      r = r / 10;
    end
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_all(input string tag);
    for (int k = 0; k < 12; k++) begin
      logic [4:0] exp_d;
      exp_d = 5'((model / pow10[k]) % 10);
      checks++;
      assert (dig[k] === exp_d) else begin
        errors++;
        $error("FAIL %s digit%0d observed=%0d expected=%0d (model=%0d)",
               tag, k, dig[k], exp_d, model);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called in the low phase of the clock; releases reset before the next
  // rising edge so that edge is the first count.
  task automatic do_reset(input logic [59:0] v, input string tag);
    rst_n = 1'b0;
    init  = v;
    #1;
    model = value_of_init(v);
    check_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      rsv = 5'($urandom_range(0, 31));
      @(posedge clk);
`ifdef COUNT_HOLD_EN
      if (!hold) model = (model + 1) % MOD;
`else
      model = (model + 1) % MOD;
`endif
      @(negedge clk);
      check_all(tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d [12];
    pow10[0] = 1;
    for (int k = 1; k < 13; k++) pow10[k] = pow10[k-1] * 10;
    model = 0;

    // Reset load and plain counting
    do_reset('0, "reset_zero");
    step(5, "count5");

    // Ones/tens both 9: ripple into hundreds
    @(negedge clk);
    for (int k = 0; k < 12; k++) d[k] = 0;
    d[0] = 9; d[1] = 9;
    do_reset(pack_digits(d), "reset_99");
    step(1, "ripple_99");

    // Full wrap
    @(negedge clk);
    for (int k = 0; k < 12; k++) d[k] = 9;
    do_reset(pack_digits(d), "reset_all9");
    step(1, "full_wrap");
    step(1, "after_wrap");

    // Mid-count reset, applied between edges, no clock needed
    @(negedge clk);
    do_reset('0, "reset_mid0");
    step(37, "count37");
    #2;
    rst_n = 1'b0;
    init  = 60'd4;
    #1;
    model = 4;
    check_all("mid_reset");
    init = 60'd7;
    #1;
    model = 7;
    check_all("init_track");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, "after_mid");

    // Invalid preload slices load as 0
    @(negedge clk);
    for (int k = 0; k < 12; k++) d[k] = 0;
    d[0] = 15; d[1] = 12; d[5] = 3;
    do_reset(pack_digits(d), "reset_invalid");
    step(1, "invalid_step");

    // Hold input
    @(negedge clk);
    do_reset('0, "reset_hold");
    step(12, "count12");
    hold = 1'b1;
    step(4, "hold4");
    hold = 1'b0;
    step(1, "release_hold");

    // Randomized: carry-heavy preloads, random run lengths, random hold
    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      hold = 1'b0;
      for (int k = 0; k < 12; k++)
        d[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 9;
      if (t % 5 == 0) begin
        longint r = (longint'($urandom) * 1000 + longint'($urandom_range(0, 999))) % MOD;
        do_reset(pack_value(r), "rand_reset_val");
      end else begin
        do_reset(pack_digits(d), "rand_reset");
      end
      for (int s = 0; s < int'($urandom_range(1, 30)); s++) begin
        hold = ($urandom_range(0, 3) == 0);
        step(1, "rand_step");
      end
      hold = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/test_decade_counter.md
Name: test_decade_counter

Overview:
- 12-digit synchronous decimal (BCD-style) up-counter, ones through hundred-billions.
- Each digit is presented as a 5-bit value.
- The counter preloads from a 60-bit init vector while reset is asserted, then advances by one on every clock.
- Sits in the tiny-tapeout-style wrapper: clock and reset arrive on the packed `io_in` bus, and the counter is used as a visible digit source for display logic.

Parameters:
- None. Digit count (12) and digit width (5) are fixed.

Ports:
- `io_in`  input  8  packed control bus.
  - `io_in[0]`: clock, rising edge.
  - `io_in[1]`: reset, asynchronous, active-low.
  - `io_in[2]`: see Optional Feature.
  - `io_in[7:3]`: reserved, ignored.
- `init`  input  60  preload value, 12 digits × 5 bits. `init[4:0]` = ones, `init[9:5]` = tens, …, `init[59:55]` = hundred-billions.
- `ones`  output  5  digit 0 (10^0)
- `tens`  output  5  digit 1 (10^1)
- `hund`  output  5  digit 2 (10^2)
- `thou`  output  5  digit 3 (10^3)
- `tenT`  output  5  digit 4 (10^4)
- `hunT`  output  5  digit 5 (10^5)
- `mil`  output  5  digit 6 (10^6)
- `tenM`  output  5  digit 7 (10^7)
- `hunM`  output  5  digit 8 (10^8)
- `bil`  output  5  digit 9 (10^9)
- `tenB`  output  5  digit 10 (10^10)
- `hunB`  output  5  digit 11 (10^11)

Behaviour:
- Clock: `io_in[0]`, single clock domain. Reset: `io_in[1]`, asynchronous, active-low.
- While reset is low, each digit register is forced asynchronously to its `init` slice.
  - A slice value above 9 loads as 0.
  - All outputs track `init` combinationally-through-reset while reset is held; `init` changes during reset propagate.
- Reset release: the first count occurs on the first rising clock edge after `io_in[1]` goes high. No extra latency cycle.
- Each rising edge with reset high: the 12-digit value increments by 1 in decimal.
  - Digit k increments when all digits below it equal 9.
  - A digit at 9 that increments wraps to 0.
  - Digit 0 always increments.
- Full wrap: 999,999,999,999 → 000,000,000,000 on one edge. No carry-out, no sticky flag.
- Outputs are direct register values. Bit 4 of every digit is always 0 in normal operation; it is kept for width compatibility with display logic.
- Robustness: if a digit register ever holds a value above 9, it is treated as 9 for carry generation and goes to 0 when incremented.
- Reset asserted mid-count: outputs immediately return to the `init`-derived values, with no clock needed. Any pending carry is discarded.
- Reserved `io_in` bits have no effect on state.

Optional Feature:
- Macro: `COUNT_HOLD_EN`.
- Defined: `io_in[2]` is an active-high hold. When `io_in[2]` is 1 on a rising edge, all digits keep their value. When it is 0, counting proceeds as above. Hold has no effect during reset.
- Not defined: `io_in[2]` is ignored and the counter advances on every edge.
- Either way, with `io_in[2]` = 0 behaviour is identical.

Test Plan:
- Reset load: `init` = all digit slices 0, hold reset low, then release and apply 5 clocks → `ones` = 5, all other digits 0.
- Preload and ripple carry: `init` digits = 0,0,0,0,0,0,0,0,0,0,9,9 (ones = 9, tens = 9), release, apply 1 clock → `ones` = 0, `tens` = 0, `hund` = 1.
- Full wrap: all 12 `init` digits = 9, release, apply 1 clock → all outputs 0. Apply 1 more clock → `ones` = 1.
- Mid-count reset: count from 0 to 37, pulse reset low between clock edges with `init` ones = 4 → `ones` = 4, `tens` = 0 immediately, before any clock edge.
- Invalid preload: `init[4:0]` = 5'd15 → `ones` = 0 while in reset. After 1 clock, `ones` = 1.
- Hold (`COUNT_HOLD_EN` defined): count to 12, drive `io_in[2]` = 1 for 4 clocks → value stays 12. Drive `io_in[2]` = 0 and apply 1 clock → 13.
